// File: rtl/fluid_seq_pkg.sv
// fluid_seq_pkg: shared states, stroke step patterns and port counts for the fluid route sequencer
package fluid_seq_pkg;
    typedef enum logic [2:0] {IDLE, OPEN_IN, FILL, MIX, OPEN_OUT, DRAIN, CLOSE, DONE} state_t;
    localparam logic [2:0] STEP_0 = 3'b011;
    localparam logic [2:0] STEP_1 = 3'b101;
    localparam logic [2:0] STEP_2 = 3'b110;
    localparam logic [2:0] PAT_IDLE = 3'b111;
    localparam int NUM_INLETS = 5;
    localparam int NUM_OUTLETS = 5;
    function automatic logic [2:0] step_pattern(input logic [1:0] step);
        return step == 2'd0 ? STEP_0 : step == 2'd1 ? STEP_1 : STEP_2;
    endfunction
endpackage

// File: rtl/peristaltic_driver.sv
// peristaltic_driver: runs strokes while start is held, counters return to zero as soon as it drops
module peristaltic_driver
    import fluid_seq_pkg::*;
#(
    parameter int PHASE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] strokes,
    output logic [2:0] pattern,
    output logic       last
);
    logic [7:0] phase_cnt;
    logic [7:0] stroke_cnt;
    logic [1:0] step_cnt;
    logic       phase_end;
    assign phase_end = phase_cnt == 8'(PHASE_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
            step_cnt <= '0;
            stroke_cnt <= '0;
        end else if (!start) begin
            phase_cnt <= '0;
            step_cnt <= '0;
            stroke_cnt <= '0;
        end else if (phase_end) begin
            phase_cnt <= '0;
            step_cnt <= step_cnt == 2'd2 ? 2'd0 : step_cnt + 2'd1;
            stroke_cnt <= step_cnt == 2'd2 ? stroke_cnt + 8'd1 : stroke_cnt;
        end else begin
            phase_cnt <= phase_cnt + 8'd1;
        end
    end
    assign pattern = start ? step_pattern(step_cnt) : PAT_IDLE;
    assign last = start && phase_end && step_cnt == 2'd2 && stroke_cnt == strokes - 8'd1;
endmodule

// File: rtl/fluid_route_sequencer.sv
// fluid_route_sequencer: routes one inlet through fill, mix and drain pumps to one outlet
module fluid_route_sequencer
    import fluid_seq_pkg::*;
#(
    parameter int PHASE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_src,
    input  logic [2:0] cmd_dst,
    input  logic [7:0] cmd_volume,
    input  logic [7:0] cmd_mix,
    input  logic       abort,
    output logic [4:0] in_valve,
    output logic [4:0] out_valve,
    output logic [2:0] pump_a,
    output logic [2:0] pump_c,
    output logic [2:0] mixer,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       err
);
    state_t     state, state_d;
    logic [2:0] src_q, dst_q;
    logic [7:0] vol_q, mix_q, settle_cnt;
    logic       err_q, abort_q;
    logic       cmd_ok, accept, settle_end, abortable;
    logic       fill_last, mix_last, drain_last;
    assign cmd_ok = cmd_src < 3'(NUM_INLETS) && cmd_dst < 3'(NUM_OUTLETS) && cmd_volume != 8'd0;
    assign accept = cmd_valid && state == IDLE;
    assign settle_end = settle_cnt == 8'(SETTLE_CYCLES - 1);
    assign abortable = abort && state inside {OPEN_IN, FILL, MIX, OPEN_OUT, DRAIN};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            err_q <= 1'b0;
            abort_q <= 1'b0;
            src_q <= '0;
            dst_q <= '0;
            vol_q <= '0;
            mix_q <= '0;
        end else begin
            settle_cnt <= (state_d == state && state inside {OPEN_IN, OPEN_OUT, CLOSE}) ? settle_cnt + 8'd1 : '0;
            err_q <= accept && !cmd_ok;
            abort_q <= state == IDLE ? 1'b0 : abort_q || abortable;
            if (accept && cmd_ok) begin
                src_q <= cmd_src;
                dst_q <= cmd_dst;
                vol_q <= cmd_volume;
                mix_q <= cmd_mix;
            end
        end
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE:     state_d = (accept && cmd_ok) ? OPEN_IN : IDLE;
            OPEN_IN:  state_d = abortable ? CLOSE : settle_end ? FILL : OPEN_IN;
            FILL:     state_d = abortable ? CLOSE : !fill_last ? FILL : mix_q == 8'd0 ? OPEN_OUT : MIX;
            MIX:      state_d = abortable ? CLOSE : mix_last ? OPEN_OUT : MIX;
            OPEN_OUT: state_d = abortable ? CLOSE : settle_end ? DRAIN : OPEN_OUT;
            DRAIN:    state_d = (abortable || drain_last) ? CLOSE : DRAIN;
            CLOSE:    state_d = settle_end ? DONE : CLOSE;
            DONE:     state_d = IDLE;
        endcase
    end
    always_comb begin
        in_valve = state inside {OPEN_IN, FILL} ? 5'(1) << src_q : '0;
        out_valve = state inside {OPEN_OUT, DRAIN} ? 5'(1) << dst_q : '0;
        cmd_ready = state == IDLE;
        busy = state != IDLE;
        done = state == DONE;
        aborted = state == DONE && abort_q;
        err = err_q;
    end
    peristaltic_driver #(.PHASE_CYCLES(PHASE_CYCLES)) u_fill (
        .clk(clk), .rst_n(rst_n), .start(state == FILL), .strokes(vol_q), .pattern(pump_a), .last(fill_last)
    );
    peristaltic_driver #(.PHASE_CYCLES(PHASE_CYCLES)) u_mix (
        .clk(clk), .rst_n(rst_n), .start(state == MIX), .strokes(mix_q), .pattern(mixer), .last(mix_last)
    );
    peristaltic_driver #(.PHASE_CYCLES(PHASE_CYCLES)) u_drain (
        .clk(clk), .rst_n(rst_n), .start(state == DRAIN), .strokes(vol_q), .pattern(pump_c), .last(drain_last)
    );
endmodule

// File: tb/tb_fluid_route_sequencer.sv
// tb_fluid_route_sequencer: scoreboard bench for transfer timing, rejection, abort and reset
module tb_fluid_route_sequencer;
    typedef struct {bit is_err; int cyc; bit ab;} exp_t;
    exp_t exp_q[$];
    logic       clk = 1'b0, rst_n = 1'b1, cmd_valid = 1'b0, abort = 1'b0;
    logic [2:0] cmd_src = '0, cmd_dst = '0;
    logic [7:0] cmd_volume = '0, cmd_mix = '0;
    logic       cmd_ready, busy, done, aborted, err;
    logic [4:0] in_valve, out_valve;
    logic [2:0] pump_a, pump_c, mixer;
    int         checks = 0, failures = 0, cyc = 0;
    logic [4:0] h_iv[300], h_ov[300];
    logic [2:0] h_a[300], h_c[300], h_m[300];

    fluid_route_sequencer #(.PHASE_CYCLES(4), .SETTLE_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_volume(cmd_volume), .cmd_mix(cmd_mix),
        .abort(abort), .in_valve(in_valve), .out_valve(out_valve), .pump_a(pump_a),
        .pump_c(pump_c), .mixer(mixer), .busy(busy), .done(done), .aborted(aborted), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            checks += 2;
            if (in_valve != 5'd0 && out_valve != 5'd0) begin
                failures++;
                $display("FAIL valve_exclusive cyc=%0d in_valve=%b out_valve=%b", cyc, in_valve, out_valve);
            end
            if (int'(pump_a != 3'b111) + int'(pump_c != 3'b111) + int'(mixer != 3'b111) > 1) begin
                failures++;
                $display("FAIL pump_exclusive cyc=%0d pump_a=%b pump_c=%b mixer=%b", cyc, pump_a, pump_c, mixer);
            end
        end
    end

    task automatic send(input logic [2:0] s, input logic [2:0] d, input logic [7:0] v, input logic [7:0] m, output int t);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_src = s; cmd_dst = d; cmd_volume = v; cmd_mix = m;
        t = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_src = 3'($urandom_range(0, 7)); cmd_dst = 3'($urandom_range(0, 7));
        cmd_volume = 8'($urandom); cmd_mix = 8'($urandom);
    endtask

    task automatic watch(input int t0, input int limit, output int ev, output logic got_done, output logic got_err, output logic got_ab);
        got_done = 1'b0; got_err = 1'b0; got_ab = 1'b0; ev = -1;
        for (int i = 0; i < 300; i++) begin
            h_iv[i] = 'x; h_ov[i] = 'x; h_a[i] = 'x; h_c[i] = 'x; h_m[i] = 'x;
        end
        for (int i = 0; i < limit; i++) begin
            if (cyc - t0 >= 0 && cyc - t0 < 300) begin
                h_iv[cyc - t0] = in_valve; h_ov[cyc - t0] = out_valve;
                h_a[cyc - t0] = pump_a; h_c[cyc - t0] = pump_c; h_m[cyc - t0] = mixer;
            end
            if (done || err) begin
                got_done = done; got_err = err; got_ab = aborted; ev = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_valve, out_valve} !== 10'd0) begin
            failures++; $display("FAIL reset_valves got=%b/%b want=0/0", in_valve, out_valve);
        end
        checks++;
        if ({pump_a, pump_c, mixer} !== 9'h1ff) begin
            failures++; $display("FAIL reset_pumps got=%b/%b/%b want=111", pump_a, pump_c, mixer);
        end
        checks++;
        if ({busy, done, aborted, err, cmd_ready} !== 5'b00001) begin
            failures++; $display("FAIL reset_flags got=%b want=00001", {busy, done, aborted, err, cmd_ready});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_nominal;
        int t, ev, n_in, n_out;
        logic gd, ge, ga;
        exp_t e;
        send(3'd1, 3'd3, 8'd2, 8'd1, t);
        exp_q.push_back('{1'b0, t + 85, 1'b0});
        watch(t, 200, ev, gd, ge, ga);
        e = exp_q.pop_front();
        checks++;
        if (gd !== 1'b1 || ge !== e.is_err || ev != e.cyc) begin
            failures++; $display("FAIL nominal_done got=%0d(done=%b err=%b) want=%0d", ev - t, gd, ge, e.cyc - t);
        end
        checks++;
        if (ga !== e.ab) begin
            failures++; $display("FAIL nominal_aborted got=%b want=%b", ga, e.ab);
        end
        n_in = 0; n_out = 0;
        for (int i = 0; i < 300; i++) begin
            n_in += int'(h_iv[i] === 5'b00010);
            n_out += int'(h_ov[i] === 5'b01000);
        end
        checks++;
        if (n_in != 32 || n_out != 32 || h_iv[33] !== 5'd0 || h_ov[44] !== 5'd0) begin
            failures++; $display("FAIL nominal_valves got in=%0d out=%0d want 32/32", n_in, n_out);
        end
        checks++;
        if ({h_a[9], h_a[13], h_a[17], h_a[32]} !== {3'b011, 3'b101, 3'b110, 3'b110}) begin
            failures++; $display("FAIL nominal_fill got=%b %b %b %b want=011 101 110 110", h_a[9], h_a[13], h_a[17], h_a[32]);
        end
        checks++;
        if ({h_a[33], h_m[33], h_m[44], h_m[45]} !== {3'b111, 3'b011, 3'b110, 3'b111}) begin
            failures++; $display("FAIL nominal_mix got=%b %b %b %b want=111 011 110 111", h_a[33], h_m[33], h_m[44], h_m[45]);
        end
        checks++;
        if ({h_c[52], h_c[53], h_c[76], h_c[77]} !== {3'b111, 3'b011, 3'b110, 3'b111}) begin
            failures++; $display("FAIL nominal_drain got=%b %b %b %b want=111 011 110 111", h_c[52], h_c[53], h_c[76], h_c[77]);
        end
    endtask

    task automatic test_reject;
        int t, ev;
        logic gd, ge, ga;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) send(3'd5, 3'd0, 8'd4, 8'd0, t);
            else send(3'd0, 3'd0, 8'd0, 8'd3, t);
            exp_q.push_back('{1'b1, t + 1, 1'b0});
            watch(t, 5, ev, gd, ge, ga);
            e = exp_q.pop_front();
            checks++;
            if (ge !== e.is_err || gd !== 1'b0 || ev != e.cyc) begin
                failures++; $display("FAIL reject_err%0d got=%0d(err=%b done=%b) want=%0d", k, ev - t, ge, gd, e.cyc - t);
            end
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                checks++;
                if ({busy, err, in_valve, out_valve} !== 12'd0) begin
                    failures++; $display("FAIL reject_idle%0d got busy=%b err=%b in=%b out=%b want all 0", k, busy, err, in_valve, out_valve);
                end
            end
        end
    endtask

    task automatic test_mix_zero;
        int t, ev, n_in, n_out, n_mix;
        logic gd, ge, ga;
        exp_t e;
        send(3'd0, 3'd4, 8'd2, 8'd0, t);
        exp_q.push_back('{1'b0, t + 73, 1'b0});
        watch(t, 200, ev, gd, ge, ga);
        e = exp_q.pop_front();
        checks++;
        if (gd !== 1'b1 || ev != e.cyc || ga !== e.ab) begin
            failures++; $display("FAIL mix0_done got=%0d(done=%b ab=%b) want=%0d", ev - t, gd, ga, e.cyc - t);
        end
        n_in = 0; n_out = 0; n_mix = 0;
        for (int i = 1; i <= 73; i++) begin
            n_in += int'(h_iv[i] === 5'b00001);
            n_out += int'(h_ov[i] === 5'b10000);
            n_mix += int'(h_m[i] !== 3'b111);
        end
        checks++;
        if (n_in != 32 || n_out != 32 || n_mix != 0) begin
            failures++; $display("FAIL mix0_outputs got in=%0d out=%0d mix_active=%0d want 32/32/0", n_in, n_out, n_mix);
        end
    endtask

    task automatic test_abort;
        int t, ev, n_open;
        logic gd, ge, ga;
        exp_t e;
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL abort_idle got busy=%b ready=%b want 0/1", busy, cmd_ready);
        end
        abort = 1'b0;
        send(3'd2, 3'd0, 8'd3, 8'd2, t);
        exp_q.push_back('{1'b0, t + 24, 1'b1});
        while (cyc < t + 15) @(negedge clk);
        checks++;
        if (in_valve !== 5'b00100 || pump_a === 3'b111) begin
            failures++; $display("FAIL abort_pre got in=%b pump_a=%b want 00100/active", in_valve, pump_a);
        end
        abort = 1'b1;
        @(negedge clk);
        watch(t, 40, ev, gd, ge, ga);
        abort = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (gd !== 1'b1 || ev != e.cyc || ga !== e.ab) begin
            failures++; $display("FAIL abort_done got=%0d(done=%b ab=%b) want=%0d ab=%b", ev - t, gd, ga, e.cyc - t, e.ab);
        end
        n_open = 0;
        for (int i = 16; i <= 23; i++) n_open += int'({h_iv[i], h_ov[i], h_a[i]} !== 13'b111);
        checks++;
        if (n_open != 0) begin
            failures++; $display("FAIL abort_close got %0d non-closed cycles want 0", n_open);
        end
    endtask

    task automatic test_back_to_back;
        int t, ev;
        logic gd, ge, ga;
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_src = 3'd3; cmd_dst = 3'd1; cmd_volume = 8'd1; cmd_mix = 8'd0;
        t = cyc;
        exp_q.push_back('{1'b0, t + 49, 1'b0});
        exp_q.push_back('{1'b0, t + 99, 1'b0});
        @(negedge clk);
        watch(t, 100, ev, gd, ge, ga);
        e = exp_q.pop_front();
        checks++;
        if (gd !== 1'b1 || ev != e.cyc || ga !== e.ab) begin
            failures++; $display("FAIL b2b_first got=%0d(done=%b ab=%b) want=%0d", ev - t, gd, ga, e.cyc - t);
        end
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_valve !== 5'b01000) begin
            failures++; $display("FAIL b2b_second_accept got busy=%b in=%b want 1/01000", busy, in_valve);
        end
        watch(t + 50, 100, ev, gd, ge, ga);
        e = exp_q.pop_front();
        checks++;
        if (gd !== 1'b1 || ev != e.cyc) begin
            failures++; $display("FAIL b2b_second got=%0d(done=%b) want=%0d", ev - t, gd, e.cyc - t);
        end
    endtask

    task automatic test_reset_mid;
        int t, ev;
        logic gd, ge, ga;
        exp_t e;
        send(3'd4, 3'd2, 8'd2, 8'd0, t);
        while (cyc < t + 50) @(negedge clk);
        checks++;
        if (out_valve !== 5'b00100 || pump_c === 3'b111) begin
            failures++; $display("FAIL rstmid_pre got out=%b pump_c=%b want 00100/active", out_valve, pump_c);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valve, pump_c, busy, cmd_ready} !== {5'd0, 3'b111, 1'b0, 1'b1}) begin
            failures++; $display("FAIL rstmid_async got out=%b pump_c=%b busy=%b ready=%b want 0/111/0/1", out_valve, pump_c, busy, cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cmd_valid = 1'b1; cmd_src = 3'd1; cmd_dst = 3'd1; cmd_volume = 8'd1; cmd_mix = 8'd0;
        t = cyc;
        exp_q.push_back('{1'b0, t + 49, 1'b0});
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_valve !== 5'b00010) begin
            failures++; $display("FAIL rstmid_first_cmd got busy=%b in=%b want 1/00010", busy, in_valve);
        end
        watch(t, 100, ev, gd, ge, ga);
        e = exp_q.pop_front();
        checks++;
        if (gd !== 1'b1 || ev != e.cyc || ga !== e.ab) begin
            failures++; $display("FAIL rstmid_done got=%0d(done=%b ab=%b) want=%0d", ev - t, gd, ga, e.cyc - t);
        end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_reject;
        test_mix_zero;
        test_abort;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
